// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter and its detector benches.
// Provides: state_t (2-bit FSM encoding), PAT_1100 default pattern,
//           cnt_w() helper that sizes a modulo-N counter (minimum 1 bit).
package seq_pkg;

  // Transmitter FSM states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Default pattern; the detector benches look for the same sequence.
  localparam logic [3:0] PAT_1100 = 4'b1100;

  // Bits needed to count 0..n-1. A modulo-1 counter still needs one bit of storage.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_bit_counter.sv
// Modulo-N up-counter with synchronous clear, enable and terminal-count flag.
// Ports: clk, reset (sync, active-high), clr, en in; cnt (0..N-1) and tc (cnt==N-1) out.
// Wraps from N-1 to 0, so non-power-of-two N never visits the unused codes.
module seq_bit_counter
  import seq_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = cnt_w(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  assign tc = (cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/moore_seq_tx.sv
// Serial pattern transmitter: shifts a WIDTH-bit pattern out MSB-first, repeat_n times,
// with GAP idle cycles between repetitions. All outputs are flops loaded from next-state.
// Ports: clk, reset (sync, active-high), start/pattern/repeat_n in;
//        out, valid, ready, busy, done out.
module moore_seq_tx
  import seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  output logic             out,
  output logic             valid,
  output logic             ready,
  output logic             busy,
  output logic             done
);

  localparam int BW = cnt_w(WIDTH);

  state_t           state, nxt_state;
  logic [WIDTH-1:0] pat_q, nxt_pat;
  logic [CNT_W-1:0] rep_cnt, nxt_rep;
  logic [BW-1:0]    bit_cnt, nxt_idx;
  logic             bit_tc;
  logic             gap_tc;
  logic             nxt_bit;

  // Bit index within the current repetition; cleared while idle, wraps at WIDTH-1.
  seq_bit_counter #(.N(WIDTH)) u_bit_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (state == S_IDLE),
    .en    (state == S_SHIFT),
    .cnt   (bit_cnt),
    .tc    (bit_tc)
  );

  // Idle-gap length counter, only present when a gap is configured.
  generate
    if (GAP > 0) begin : g_gap
      logic [cnt_w(GAP)-1:0] unused_gap_cnt;
      seq_bit_counter #(.N(GAP)) u_gap_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (state == S_IDLE),
        .en    (state == S_GAP),
        .cnt   (unused_gap_cnt),
        .tc    (gap_tc)
      );
    end else begin : g_no_gap
      assign gap_tc = 1'b1;
    end
  endgenerate

  // Next-state logic. nxt_idx is the bit index that will be on the wire next
  // cycle; it mirrors the counter's own wrap so the output flop can be loaded
  // one cycle ahead and stay a pure register.
  always_comb begin
    nxt_state = state;
    nxt_pat   = pat_q;
    nxt_rep   = rep_cnt;
    nxt_idx   = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          nxt_pat   = pattern;
          nxt_rep   = repeat_n;
          nxt_state = (repeat_n != '0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        if (!bit_tc) begin
          nxt_idx = bit_cnt + 1'b1;
        end else if (rep_cnt > CNT_W'(1)) begin
          nxt_rep   = rep_cnt - 1'b1;
          nxt_state = (GAP > 0) ? S_GAP : S_SHIFT;
        end else begin
          // Final repetition; guard keeps the counter from underflowing.
          nxt_rep   = (rep_cnt != '0) ? rep_cnt - 1'b1 : '0;
          nxt_state = S_DONE;
        end
      end
      S_GAP: begin
        if (gap_tc) nxt_state = S_SHIFT;
      end
      S_DONE: begin
        nxt_state = S_IDLE;
      end
      default: begin
        nxt_state = S_IDLE;
      end
    endcase
  end

  // MSB-first: index 0 selects pattern bit WIDTH-1.
  assign nxt_bit = nxt_pat[(WIDTH - 1) - int'(nxt_idx)];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      pat_q   <= '0;
      rep_cnt <= '0;
      out     <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ready   <= 1'b1;
    end else begin
      state   <= nxt_state;
      pat_q   <= nxt_pat;
      rep_cnt <= nxt_rep;
      valid   <= (nxt_state == S_SHIFT);
      out     <= (nxt_state == S_SHIFT) && nxt_bit;
      busy    <= (nxt_state == S_SHIFT) || (nxt_state == S_GAP);
      done    <= (nxt_state == S_DONE);
      ready   <= (nxt_state == S_IDLE);
    end
  end

endmodule
